// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI types and constants for the interconnect.
package axi_pkg;
    localparam int LEN_W = 8;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_t;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_mux_state_t;
endpackage

// File: rtl/axi_ar_reg.sv
// axi_ar_reg: AR payload capture register with load enable.
module axi_ar_reg #(
    parameter int W = 49
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/axi_mux_r.sv
// axi_mux_r: two-master read-channel mux; registers the granted AR and
// routes the R burst back to its owner until RLAST.
module axi_mux_r
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  m0_rgrnt,
    input  logic                  m1_rgrnt,
    input  logic [ID_WIDTH-1:0]   m0_ARID,
    input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
    input  logic [LEN_W-1:0]      m0_ARLEN,
    input  logic [2:0]            m0_ARSIZE,
    input  logic [1:0]            m0_ARBURST,
    input  logic                  m0_ARVALID,
    output logic                  m0_ARREADY,
    output logic [ID_WIDTH-1:0]   m0_RID,
    output logic [DATA_WIDTH-1:0] m0_RDATA,
    output logic [1:0]            m0_RRESP,
    output logic                  m0_RLAST,
    output logic                  m0_RVALID,
    input  logic                  m0_RREADY,
    input  logic [ID_WIDTH-1:0]   m1_ARID,
    input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
    input  logic [LEN_W-1:0]      m1_ARLEN,
    input  logic [2:0]            m1_ARSIZE,
    input  logic [1:0]            m1_ARBURST,
    input  logic                  m1_ARVALID,
    output logic                  m1_ARREADY,
    output logic [ID_WIDTH-1:0]   m1_RID,
    output logic [DATA_WIDTH-1:0] m1_RDATA,
    output logic [1:0]            m1_RRESP,
    output logic                  m1_RLAST,
    output logic                  m1_RVALID,
    input  logic                  m1_RREADY,
    output logic [ID_WIDTH-1:0]   s_ARID,
    output logic [ADDR_WIDTH-1:0] s_ARADDR,
    output logic [LEN_W-1:0]      s_ARLEN,
    output logic [2:0]            s_ARSIZE,
    output logic [1:0]            s_ARBURST,
    output logic                  s_ARVALID,
    input  logic                  s_ARREADY,
    input  logic [ID_WIDTH-1:0]   s_RID,
    input  logic [DATA_WIDTH-1:0] s_RDATA,
    input  logic [1:0]            s_RRESP,
    input  logic                  s_RLAST,
    input  logic                  s_RVALID,
    output logic                  s_RREADY,
    output logic                  m_RVALID,
    output logic                  m_RLAST,
    output logic                  owner,
    output logic                  burst_err
);
    localparam int W = ID_WIDTH + ADDR_WIDTH + LEN_W + 5;
    rd_mux_state_t    state, state_nxt;
    logic [LEN_W-1:0] beats_left, beats_nxt;
    logic             owner_nxt, err_nxt, load, sel, to_m0, to_m1;
    logic [W-1:0]     ar_d, ar_q;
    assign sel  = !m0_rgrnt;
    assign ar_d = sel ? {m1_ARID, m1_ARADDR, m1_ARLEN, m1_ARSIZE, m1_ARBURST}
                      : {m0_ARID, m0_ARADDR, m0_ARLEN, m0_ARSIZE, m0_ARBURST};
    assign {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST} = ar_q;
    axi_ar_reg #(.W(W)) u_ar_reg (
        .ACLK(ACLK), .ARESETn(ARESETn), .load(load), .d(ar_d), .q(ar_q)
    );
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            beats_left <= '0;
            burst_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            beats_left <= beats_nxt;
            burst_err  <= err_nxt;
        end
    // Reset gates ARREADY too, since IDLE is the reset state and grants may be live.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        beats_nxt  = beats_left;
        err_nxt    = burst_err;
        load       = 1'b0;
        m0_ARREADY = 1'b0;
        m1_ARREADY = 1'b0;
        s_ARVALID  = 1'b0;
        s_RREADY   = 1'b0;
        case (state)
            IDLE: begin
                m0_ARREADY = ARESETn && m0_rgrnt;
                m1_ARREADY = ARESETn && !m0_rgrnt && m1_rgrnt;
                if ((m0_ARREADY && m0_ARVALID) || (m1_ARREADY && m1_ARVALID)) begin
                    load      = 1'b1;
                    owner_nxt = sel;
                    beats_nxt = sel ? m1_ARLEN : m0_ARLEN;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_ARVALID = 1'b1;
                if (s_ARREADY) state_nxt = DATA;
            end
            DATA: begin
                s_RREADY = owner ? m1_RREADY : m0_RREADY;
                if (s_RVALID && s_RREADY) begin
                    if (s_RLAST) begin
                        state_nxt = IDLE;
                        err_nxt   = burst_err || (beats_left != '0);
                    end else if (beats_left == '0) err_nxt = 1'b1;
                    else beats_nxt = beats_left - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign to_m0     = (state == DATA) && !owner;
    assign to_m1     = (state == DATA) && owner;
    assign m0_RVALID = to_m0 && s_RVALID;
    assign m0_RID    = to_m0 ? s_RID : '0;
    assign m0_RDATA  = to_m0 ? s_RDATA : '0;
    assign m0_RRESP  = to_m0 ? s_RRESP : '0;
    assign m0_RLAST  = to_m0 && s_RLAST;
    assign m1_RVALID = to_m1 && s_RVALID;
    assign m1_RID    = to_m1 ? s_RID : '0;
    assign m1_RDATA  = to_m1 ? s_RDATA : '0;
    assign m1_RRESP  = to_m1 ? s_RRESP : '0;
    assign m1_RLAST  = to_m1 && s_RLAST;
    assign m_RVALID  = ARESETn && s_RVALID;
    assign m_RLAST   = ARESETn && s_RLAST;
endmodule

// File: tb/tb_axi_mux_r.sv
// tb_axi_mux_r: directed, table-driven and randomized checks of axi_mux_r
// against a transaction-level expectation of routing, beats and burst_err.
module tb_axi_mux_r;
    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic m0_rgrnt, m1_rgrnt;
    logic [3:0] m0_ARID, m1_ARID, s_ARID, m0_RID, m1_RID, s_RID;
    logic [31:0] m0_ARADDR, m1_ARADDR, s_ARADDR, m0_RDATA, m1_RDATA, s_RDATA;
    logic [7:0] m0_ARLEN, m1_ARLEN, s_ARLEN;
    logic [2:0] m0_ARSIZE, m1_ARSIZE, s_ARSIZE;
    logic [1:0] m0_ARBURST, m1_ARBURST, s_ARBURST, m0_RRESP, m1_RRESP, s_RRESP;
    logic m0_ARVALID, m0_ARREADY, m0_RLAST, m0_RVALID, m0_RREADY;
    logic m1_ARVALID, m1_ARREADY, m1_RLAST, m1_RVALID, m1_RREADY;
    logic s_ARVALID, s_ARREADY, s_RLAST, s_RVALID, s_RREADY;
    logic m_RVALID, m_RLAST, owner, burst_err;
    int   n_chk = 0, n_fail = 0;
    logic err_exp = 1'b0;
    typedef struct { logic g0, g1, e0, e1; } gvec_t;
    gvec_t gv[4];

    always #5 ACLK = ~ACLK;

    axi_mux_r dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .m0_rgrnt(m0_rgrnt), .m1_rgrnt(m1_rgrnt),
        .m0_ARID(m0_ARID), .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE),
        .m0_ARBURST(m0_ARBURST), .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
        .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
        .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
        .m1_ARID(m1_ARID), .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE),
        .m1_ARBURST(m1_ARBURST), .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
        .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
        .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
        .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
        .s_ARBURST(s_ARBURST), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .m_RVALID(m_RVALID), .m_RLAST(m_RLAST), .owner(owner), .burst_err(burst_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_ar(input int m, input logic v, input logic [3:0] id,
                            input logic [31:0] a, input logic [7:0] len);
        if (m == 0) begin
            m0_ARVALID = v; m0_ARID = id; m0_ARADDR = a; m0_ARLEN = len;
            m0_ARSIZE = 3'd2; m0_ARBURST = 2'b01;
        end else begin
            m1_ARVALID = v; m1_ARID = id; m1_ARADDR = a; m1_ARLEN = len;
            m1_ARSIZE = 3'd2; m1_ARBURST = 2'b01;
        end
    endtask

    function automatic logic arready(input int m);
        return (m != 0) ? m1_ARREADY : m0_ARREADY;
    endfunction

    task automatic set_rready(input int m, input logic v);
        if (m == 0) begin m0_RREADY = v; m1_RREADY = ~v; end
        else begin m1_RREADY = v; m0_RREADY = ~v; end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_arvalid"}, s_ARVALID, 0);
        chk({tag, "_s_rready"}, s_RREADY, 0);
        chk({tag, "_m0_arready"}, m0_ARREADY, 0);
        chk({tag, "_m1_arready"}, m1_ARREADY, 0);
        chk({tag, "_m0_rvalid"}, m0_RVALID, 0);
        chk({tag, "_m1_rvalid"}, m1_RVALID, 0);
        chk({tag, "_m_rvalid"}, m_RVALID, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_burst_err"}, burst_err, 0);
        chk({tag, "_s_ar_payload"}, {s_ARID, s_ARADDR, s_ARLEN}, 0);
    endtask

    task automatic rst_pulse;
        ARESETn = 1'b0;
        #1;
        check_all_zero("rst");
        step;
        step;
        ARESETn = 1'b1;
        err_exp = 1'b0;
    endtask

    // One read transaction: master m issues AR, slave returns nbeats beats.
    task automatic do_read(input int m, input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input int nbeats, input bit bp,
                           input bit flip, input int rst_after, output int waited);
        logic [31:0] d;
        logic [1:0]  rr;
        logic        rdy, aborted;
        int          b, t, ad;
        aborted = 1'b0;
        drive_ar(m, 1, id, a, len);
        waited = 0;
        #1;
        while (!arready(m) && waited < 20) begin step; #1; waited++; end
        chk("ar_ready", arready(m), 1);
        step;
        drive_ar(m, 0, id, a, len);
        #1;
        chk("s_arvalid", s_ARVALID, 1);
        chk("s_ar_payload", {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST},
            {id, a, len, 3'd2, 2'b01});
        chk("owner", owner, m);
        ad = $urandom_range(0, 2);
        repeat (ad) begin
            step; #1;
            chk("s_arvalid_hold", s_ARVALID, 1);
            chk("s_araddr_hold", s_ARADDR, a);
        end
        s_ARREADY = 1'b1;
        step;
        s_ARREADY = 1'b0;
        if (flip) begin
            m0_rgrnt = 0; m1_rgrnt = 1;
            drive_ar(1, 1, 4'h9, 32'h2000, 8'd0);
        end
        b = 0; t = 0;
        while (b < nbeats && t < 2000 && !aborted) begin
            d = $urandom; rr = 2'($urandom);
            s_RVALID = 1; s_RLAST = (b == nbeats - 1); s_RDATA = d; s_RID = id; s_RRESP = rr;
            rdy = bp ? (t % 2 == 0) : 1'b1;
            set_rready(m, rdy);
            #1;
            chk("own_rvalid", (m != 0) ? m1_RVALID : m0_RVALID, 1);
            chk("own_rpayload", (m != 0) ? {m1_RID, m1_RDATA, m1_RRESP, m1_RLAST}
                                         : {m0_RID, m0_RDATA, m0_RRESP, m0_RLAST},
                {id, d, rr, s_RLAST});
            chk("other_r", (m != 0) ? {m0_RVALID, m0_RDATA} : {m1_RVALID, m1_RDATA}, 0);
            chk("s_rready", s_RREADY, rdy);
            chk("m_rvalid_rlast", {m_RVALID, m_RLAST}, {1'b1, s_RLAST});
            chk("owner_data", owner, m);
            if (flip) chk("flip_ar_blocked", m1_ARREADY, 0);
            step;
            t++;
            if (rdy) begin
                if ((b == nbeats - 1 && b != len) || (b != nbeats - 1 && b >= len)) err_exp = 1;
                b++;
                chk("burst_err", burst_err, err_exp);
                if (b == rst_after) begin
                    ARESETn = 1'b0;
                    #1;
                    check_all_zero("mid_rst");
                    chk("mid_rst_m_rlast", m_RLAST, 0);
                    s_RVALID = 0; s_RLAST = 0;
                    step; step;
                    ARESETn = 1'b1;
                    err_exp = 0;
                    aborted = 1'b1;
                end
            end
        end
        s_RVALID = 0; s_RLAST = 0;
        m0_RREADY = 0; m1_RREADY = 0;
        if (!aborted) begin
            chk("beats", b, nbeats);
            #1;
            chk("idle_s_arvalid", {s_ARVALID, s_RREADY}, 0);
            chk("idle_arready", arready(m0_rgrnt ? 0 : 1), m0_rgrnt | m1_rgrnt);
        end
    endtask

    initial begin
        int w, m, other;
        logic [3:0] id;
        logic [7:0] len;
        gv[0] = '{0, 0, 0, 0};
        gv[1] = '{1, 0, 1, 0};
        gv[2] = '{0, 1, 0, 1};
        gv[3] = '{1, 1, 1, 0};
        m0_rgrnt = 1; m1_rgrnt = 1;
        drive_ar(0, 0, 0, 0, 0); drive_ar(1, 0, 0, 0, 0);
        m0_RREADY = 0; m1_RREADY = 0;
        s_ARREADY = 0; s_RVALID = 0; s_RLAST = 0; s_RID = 0; s_RDATA = 0; s_RRESP = 0;
        #1;
        check_all_zero("reset");
        step; step;
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_rgrnt = gv[i].g0; m1_rgrnt = gv[i].g1;
            #1;
            chk("grant_tbl", {m0_ARREADY, m1_ARREADY}, {gv[i].e0, gv[i].e1});
        end
        step;
        m0_rgrnt = 1; m1_rgrnt = 0;
        do_read(0, 4'd3, 32'h1000, 8'd0, 1, 0, 0, -1, w);
        m0_rgrnt = 0; m1_rgrnt = 1;
        do_read(1, 4'd6, 32'h4000, 8'd3, 4, 1, 0, -1, w);
        m0_rgrnt = 1; m1_rgrnt = 0;
        do_read(0, 4'd5, 32'h3000, 8'd1, 2, 0, 1, -1, w);
        do_read(1, 4'h9, 32'h2000, 8'd0, 1, 0, 0, -1, w);
        chk("flip_capture_wait", w, 0);
        m0_rgrnt = 1; m1_rgrnt = 0;
        do_read(0, 4'd1, 32'h8000, 8'd255, 256, 0, 0, -1, w);
        do_read(0, 4'd2, 32'h100, 8'd1, 3, 0, 0, -1, w);
        step;
        rst_pulse;
        do_read(0, 4'd2, 32'h200, 8'd3, 2, 0, 0, -1, w);
        do_read(0, 4'd7, 32'h300, 8'd0, 1, 1, 0, -1, w);
        do_read(0, 4'd4, 32'h400, 8'd3, 4, 0, 0, 1, w);
        do_read(0, 4'd4, 32'h500, 8'd2, 3, 1, 0, -1, w);
        for (int i = 0; i < 40; i++) begin
            m0_rgrnt = 1'($urandom); m1_rgrnt = m0_rgrnt ? 1'($urandom) : 1'b1;
            m = m0_rgrnt ? 0 : 1;
            other = 1 - m;
            id = 4'($urandom);
            len = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) drive_ar(other, 1, ~id, 32'hDEAD0000, 8'd7);
            do_read(m, id, $urandom, len,
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : int'(len) + 1,
                    1'($urandom), 0, -1, w);
            drive_ar(other, 0, 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
